// File: rtl/switch_allocator.sv
// switch_allocator
//   Per-output round-robin allocator for the router crossbar. Every output
//   owns a small IDLE/BUSY machine, an owner register and a round-robin
//   pointer. An IDLE output picks the first requesting, not-yet-granted
//   input after its pointer. A BUSY output keeps its owner for as long as
//   that input keeps requesting the same output. All outputs come straight
//   from flops, so no input reaches an output combinationally.
//
// Ports
//   clk        single clock
//   reset      asynchronous, active-high; clears every grant at once
//   sw_req     request from input i (bit i)
//   sw_chnl    requested output of input i in [i*CHANNEL_BITS +: CHANNEL_BITS]
//   sw_gnt     input i currently owns some output
//   out_valid  output j currently owned
//   out_sel    index of the input owning output j (0 while not owned)
module switch_allocator #(
    parameter int PORTS        = 5,
    parameter int CHANNEL_BITS = 3
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [PORTS-1:0]                sw_req,
    input  logic [PORTS*CHANNEL_BITS-1:0]   sw_chnl,
    output logic [PORTS-1:0]                sw_gnt,
    output logic [PORTS-1:0]                out_valid,
    output logic [PORTS*CHANNEL_BITS-1:0]   out_sel
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                  state     [PORTS];
    state_t                  state_nxt [PORTS];
    logic [CHANNEL_BITS-1:0] owner     [PORTS];
    logic [CHANNEL_BITS-1:0] owner_nxt [PORTS];
    logic [CHANNEL_BITS-1:0] ptr       [PORTS];
    logic [CHANNEL_BITS-1:0] ptr_nxt   [PORTS];

    // want[j][i]: input i is requesting output j. Out-of-range channel
    // numbers never match any j, so they can neither win nor move a pointer.
    logic [PORTS-1:0]        want      [PORTS];
    logic [CHANNEL_BITS:0]   pick      [PORTS];
    logic                    hold      [PORTS];

    logic [PORTS-1:0]              gnt_nxt;
    logic [PORTS-1:0]              valid_nxt;
    logic [PORTS*CHANNEL_BITS-1:0] sel_nxt;

    // Round-robin search starting just after 'last', wrapping at PORTS.
    // Returns {found, index}.
    function automatic logic [CHANNEL_BITS:0] rr_pick(
        input logic [PORTS-1:0]        cand,
        input logic [CHANNEL_BITS-1:0] last
    );
        logic                    found;
        logic [CHANNEL_BITS-1:0] idx;
        int                      slot;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= PORTS; k++) begin
            slot = int'(last) + k;
            if (slot >= PORTS) begin
                slot = slot - PORTS;
            end
            for (int i = 0; i < PORTS; i++) begin
                if (!found && (slot == i) && cand[i]) begin
                    found = 1'b1;
                    idx   = CHANNEL_BITS'(i);
                end
            end
        end
        return {found, idx};
    endfunction

    always_comb begin
        gnt_nxt   = '0;
        valid_nxt = '0;
        sel_nxt   = '0;
        for (int j = 0; j < PORTS; j++) begin
            want[j]      = '0;
            hold[j]      = 1'b0;
            state_nxt[j] = state[j];
            owner_nxt[j] = owner[j];
            ptr_nxt[j]   = ptr[j];
            for (int i = 0; i < PORTS; i++) begin
                want[j][i] = sw_req[i] &&
                             (sw_chnl[i*CHANNEL_BITS +: CHANNEL_BITS] == CHANNEL_BITS'(j));
            end
            // Inputs already holding a grant (registered) are excluded, so an
            // input that just switched channel waits for its old grant to drop.
            pick[j] = rr_pick(want[j] & ~sw_gnt, ptr[j]);
            for (int i = 0; i < PORTS; i++) begin
                if ((owner[j] == CHANNEL_BITS'(i)) && want[j][i]) begin
                    hold[j] = 1'b1;
                end
            end

            case (state[j])
                IDLE: begin
                    if (pick[j][CHANNEL_BITS]) begin
                        state_nxt[j] = BUSY;
                        owner_nxt[j] = pick[j][CHANNEL_BITS-1:0];
                        ptr_nxt[j]   = pick[j][CHANNEL_BITS-1:0];
                    end
                end
                BUSY: begin
                    // Release goes straight to IDLE; arbitration happens on
                    // the following edge, giving one idle cycle between owners.
                    if (!hold[j]) begin
                        state_nxt[j] = IDLE;
                    end
                end
                default: begin
                    state_nxt[j] = IDLE;
                end
            endcase

            if (state_nxt[j] == BUSY) begin
                valid_nxt[j] = 1'b1;
                sel_nxt[j*CHANNEL_BITS +: CHANNEL_BITS] = owner_nxt[j];
                for (int i = 0; i < PORTS; i++) begin
                    if (owner_nxt[j] == CHANNEL_BITS'(i)) begin
                        gnt_nxt[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < PORTS; j++) begin
                state[j] <= IDLE;
                owner[j] <= '0;
                // Pointer at the last input puts input 0 first after reset.
                ptr[j]   <= CHANNEL_BITS'(PORTS - 1);
            end
            sw_gnt    <= '0;
            out_valid <= '0;
            out_sel   <= '0;
        end else begin
            for (int j = 0; j < PORTS; j++) begin
                state[j] <= state_nxt[j];
                owner[j] <= owner_nxt[j];
                ptr[j]   <= ptr_nxt[j];
            end
            sw_gnt    <= gnt_nxt;
            out_valid <= valid_nxt;
            out_sel   <= sel_nxt;
        end
    end

endmodule
